rf_writeback: RTL and testbench
===============================

RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, meaning the result data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 4, meaning the register-address width, with 2**ADDRESS_WIDTH registers.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning per-port FIFO entries; it is a power of two and at least 2.
REQ-004 The block SHALL have parameter SEQ_WIDTH, default 6, meaning the width of the issue sequence tag.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port arst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports valid_i and ready_o, input and output, [3:0]: the per-port result handshake (port 0 arithmetic, 1 logic, 2 and 3 shift).
REQ-008 The block SHALL have ports addr_i, data_i and seq_i, inputs, [3:0] x ADDRESS_WIDTH, WORD_WIDTH and SEQ_WIDTH: the per-port destination register, result value and issue tag.
REQ-009 The block SHALL have output select_r_o, [3:0] x ADDRESS_WIDTH: the register-file write address per port.
REQ-010 The block SHALL have output data_o, [3:0] x WORD_WIDTH: the register-file write data per port.
REQ-011 The block SHALL have output enable_writing_o, [3:0]: the register-file write enable per port.
REQ-012 The block SHALL have output idle_o, 1 bit: high when all FIFOs are empty and no write enable is asserted.

Function
REQ-013 Port i SHALL accept an entry on a rising edge where valid_i[i] and ready_o[i] are both high; ready_o[i] = FIFO i not full (no same-cycle pass-through when full).
REQ-014 Each port SHALL buffer accepted entries in its own in-order FIFO of DEPTH entries; pointers wrap modulo DEPTH; a push and a pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
REQ-015 Every cycle, the head entry of each non-empty FIFO SHALL be a candidate for issue.
REQ-016 When two candidates share an address, the one with the older seq SHALL issue and the other SHALL be held; a is older than b when bit SEQ_WIDTH-1 of (seq_a - seq_b) modulo 2**SEQ_WIDTH is set.
REQ-017 Equal seq on a same-address pair SHALL resolve in favour of the higher port index.
REQ-018 A candidate SHALL issue only if it is older than every other same-address candidate, so no issue group ever contains a duplicate address.
REQ-019 Issued heads SHALL be popped on that edge, with select_r_o[i], data_o[i] and enable_writing_o[i] registered from them on the same edge.
REQ-020 A non-issuing port SHALL drive enable_writing_o[i] = 0 and hold its previous select_r_o[i] and data_o[i].
REQ-021 Latency SHALL be two edges: an entry accepted at edge k into an empty FIFO, with no conflict, drives enable_writing_o in the cycle after edge k+1.
REQ-022 A held entry SHALL retry every cycle; if it becomes the oldest same-address candidate, it SHALL issue; no entry is ever dropped except per REQ-026.

Reset
REQ-023 While arst_n_i is low: FIFOs empty, pointers 0, select_r_o = 0, data_o = 0, enable_writing_o = 0, ready_o = 0, idle_o = 1.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries immediately, with no write issued afterwards.
REQ-025 ready_o SHALL rise on the first cycle after arst_n_i deasserts.

Configuration
REQ-026 With macro RF_WRITEBACK_ZERO_REG_EN defined, entries with addr_i = 0 SHALL be accepted per the handshake but never pushed, and SHALL never raise enable_writing_o; without it, address 0 SHALL be treated as any other register.

Structure
REQ-027 Package wb_pkg SHALL hold NUM_PORTS = 4, port index constants (PORT_ARITH, PORT_LOGIC, PORT_SHIFT0, PORT_SHIFT1) and the modular seq_older function.
REQ-028 One sub-module, wb_fifo (single-clock FIFO, parameters WIDTH and DEPTH, with full, empty, push and pop), SHALL be instantiated once per port.

Verification
REQ-029 The bench SHALL cover: reset release, then port 0 pushes addr 5, data 0xA5, seq 1 at edge k -> enable_writing_o[0] = 1, select_r_o[0] = 5, data_o[0] = 0xA5 for exactly one cycle after edge k+1.
REQ-030 The bench SHALL cover: ports 1 and 3 push addr 7 in the same cycle, seq 4 and 3 -> port 3 writes first, port 1 writes one cycle later, with no cycle where both enables are high.
REQ-031 The bench SHALL cover: seq wrap, port 0 seq 63 and port 2 seq 0, same address -> port 0 issues first.
REQ-032 The bench SHALL cover: DEPTH+1 back-to-back pushes to port 2 while it is blocked by an older same-address head on port 3 -> ready_o[2] falls after DEPTH accepts, and all DEPTH entries later issue in order.
REQ-033 The bench SHALL cover: arst_n_i pulsed low with 3 entries buffered -> enable_writing_o = 0, idle_o = 1, and no later writes.
REQ-034 The bench SHALL cover: with RF_WRITEBACK_ZERO_REG_EN defined, a push to addr 0 -> ready_o stays 1, no enable pulse, idle_o stays 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback block.
//   NUM_PORTS    : number of result ports feeding the writeback stage
//   PORT_*       : port index of each execution unit
//   seq_older()  : modular age compare of two issue tags
package wb_pkg;

  localparam int unsigned NUM_PORTS   = 4;
  localparam int unsigned PORT_ARITH  = 0;
  localparam int unsigned PORT_LOGIC  = 1;
  localparam int unsigned PORT_SHIFT0 = 2;
  localparam int unsigned PORT_SHIFT1 = 3;

  // seq_a is older than seq_b when the top bit of (seq_a - seq_b) mod 2**width
  // is set. Tags are zero-extended to 32 bits; the low bits of the difference
  // are unaffected by the extension.
  function automatic logic seq_older(input logic [31:0]   seq_a,
                                     input logic [31:0]   seq_b,
                                     input int unsigned   width);
    logic [31:0] diff;
    diff = seq_a - seq_b;
    return diff[5'(width - 1)];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-clock in-order FIFO, one per writeback port.
//   clk_i, arst_n_i : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     : write request and data (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   rdata           : head entry, valid while empty is low
//   full, empty     : occupancy flags
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter. Four result ports (0 arith, 1 logic,
// 2/3 shift) each queue results in a FIFO; every cycle the FIFO heads compete
// and, among heads targeting the same register, only the oldest (by modular
// seq tag, ties to the higher port) writes. Writes are registered.
//   clk_i, arst_n_i     : clock, asynchronous active-low reset
//   valid_i / ready_o   : per-port result handshake
//   addr_i, data_i, seq_i : per-port destination, value, issue tag
//   select_r_o, data_o, enable_writing_o : per-port register-file write
//   idle_o              : no buffered entries and no write in progress
// Build option: RF_WRITEBACK_ZERO_REG_EN -- results for register 0 are
// accepted but discarded (hard-wired zero register).
module rf_writeback
  import wb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SEQ_WIDTH     = 6
) (
  input  logic                                       clk_i,
  input  logic                                       arst_n_i,
  input  logic [NUM_PORTS-1:0]                       valid_i,
  output logic [NUM_PORTS-1:0]                       ready_o,
  input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]       data_i,
  input  logic [NUM_PORTS-1:0][SEQ_WIDTH-1:0]        seq_i,
  output logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]    select_r_o,
  output logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]       data_o,
  output logic [NUM_PORTS-1:0]                       enable_writing_o,
  output logic                                       idle_o
);

  localparam int unsigned EW = SEQ_WIDTH + ADDRESS_WIDTH + WORD_WIDTH;

  logic [NUM_PORTS-1:0]                    full;
  logic [NUM_PORTS-1:0]                    empty;
  logic [NUM_PORTS-1:0]                    push;
  logic [NUM_PORTS-1:0]                    issue;
  logic [NUM_PORTS-1:0][EW-1:0]            head;
  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] head_addr;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]    head_data;
  logic [NUM_PORTS-1:0][SEQ_WIDTH-1:0]     head_seq;

  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] sel_q;
  logic [NUM_PORTS-1:0][WORD_WIDTH-1:0]    data_q;
  logic [NUM_PORTS-1:0]                    en_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .push     (push[g]),
      .wdata    ({seq_i[g], addr_i[g], data_i[g]}),
      .pop      (issue[g]),
      .rdata    (head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
    assign {head_seq[g], head_addr[g], head_data[g]} = head[g];
  end

  // Gating with the reset input holds ready low while reset is asserted and
  // lets it rise in the first cycle after release.
  assign ready_o = ~full & {NUM_PORTS{arst_n_i}};

  always_comb begin
    push = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
`ifdef RF_WRITEBACK_ZERO_REG_EN
      push[p] = valid_i[p] & ready_o[p] & (addr_i[p] != '0);
`else
      push[p] = valid_i[p] & ready_o[p];
`endif
    end
  end

  // A head issues only if it beats every other same-address head. The pairwise
  // "beats" relation is made strictly antisymmetric: when the modular compare
  // is inconclusive (equal tags, or tags exactly half the range apart) the
  // higher port wins, so two heads can never both win on the same address.
  logic older_ij;
  logic older_ji;
  logic wins;

  always_comb begin
    issue    = '0;
    older_ij = 1'b0;
    older_ji = 1'b0;
    wins     = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      issue[i] = ~empty[i];
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (j != i && !empty[j] && head_addr[j] == head_addr[i]) begin
          older_ij = seq_older(32'(head_seq[i]), 32'(head_seq[j]), SEQ_WIDTH);
          older_ji = seq_older(32'(head_seq[j]), 32'(head_seq[i]), SEQ_WIDTH);
          wins     = (older_ij != older_ji) ? older_ij : (i > j);
          if (!wins) issue[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sel_q  <= '0;
      data_q <= '0;
      en_q   <= '0;
    end else begin
      en_q <= issue;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (issue[p]) begin
          sel_q[p]  <= head_addr[p];
          data_q[p] <= head_data[p];
        end
      end
    end
  end

  assign select_r_o       = sel_q;
  assign data_o           = data_q;
  assign enable_writing_o = en_q;
  assign idle_o           = (&empty) & ~(|en_q);

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed pushes, with each expected
// write (port, address, data, cycle) queued in a scoreboard and matched by a
// monitor that samples the write outputs on the falling clock edge.
module tb_rf_writeback;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned SW = 6;

  logic                clk = 1'b0;
  logic                arst_n = 1'b0;
  logic [3:0]          valid;
  logic [3:0]          ready;
  logic [3:0][AW-1:0]  addr;
  logic [3:0][WW-1:0]  data;
  logic [3:0][SW-1:0]  seq;
  logic [3:0][AW-1:0]  sel;
  logic [3:0][WW-1:0]  dout;
  logic [3:0]          en;
  logic                idle;

  rf_writeback #(
    .WORD_WIDTH    (WW),
    .ADDRESS_WIDTH (AW),
    .DEPTH         (D),
    .SEQ_WIDTH     (SW)
  ) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .valid_i          (valid),
    .ready_o          (ready),
    .addr_i           (addr),
    .data_i           (data),
    .seq_i            (seq),
    .select_r_o       (sel),
    .data_o           (dout),
    .enable_writing_o (en),
    .idle_o           (idle)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned    port;
    logic [AW-1:0]  a;
    logic [WW-1:0]  d;
    int unsigned    c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp_v, cyc);
    end
  endtask

  task automatic expect_wr(input int unsigned p, input logic [AW-1:0] a,
                           input logic [WW-1:0] d, input int unsigned c);
    exp_t e;
    e.port = p; e.a = a; e.d = d; e.c = c;
    sb.push_back(e);
  endtask

  task automatic set_port(input int unsigned p, input logic [AW-1:0] a,
                          input logic [WW-1:0] d, input logic [SW-1:0] s);
    valid[p] = 1'b1;
    addr[p]  = a;
    data[p]  = d;
    seq[p]   = s;
  endtask

  task automatic step();
    @(negedge clk);
    valid = '0;
  endtask

  // Monitor: every asserted enable must match the oldest pending expectation
  // for that port, including the cycle it appears in.
  int idx;
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (en[p]) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].port == p) idx = k;
        if (idx < 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wr_p%0d: got write addr %0h data %0h, required none (cycle %0d)",
                   p, sel[p], dout[p], cyc);
        end else begin
          chk($sformatf("wr_p%0d_addr", p), sel[p], sb[idx].a);
          chk($sformatf("wr_p%0d_data", p), dout[p], sb[idx].d);
          chk($sformatf("wr_p%0d_cycle", p), cyc, sb[idx].c);
          sb.delete(idx);
        end
      end
    end
    for (int p = 0; p < 4; p++)
      for (int q = p + 1; q < 4; q++)
        if (en[p] && en[q])
          chk($sformatf("dup_addr_p%0d_p%0d", p, q), sel[p] == sel[q], 1'b0);
  end

  int unsigned c0;

  initial begin
    valid = '0; addr = '0; data = '0; seq = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", en, 4'h0);
    chk("rst_ready", ready, 4'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_sel", sel, '0);
    chk("rst_data", dout, '0);
    arst_n = 1'b1;
    #1;
    chk("ready_release", ready, 4'hF);
    step();

    // Single push, two-edge latency, one-cycle pulse
    c0 = cyc;
    set_port(0, 4'd5, 32'hA5, 6'd1);
    expect_wr(0, 4'd5, 32'hA5, c0 + 2);
    step();
    chk("single_idle_busy", idle, 1'b0);
    repeat (4) step();
    chk("single_idle_after", idle, 1'b1);

    // Same address, port 3 older
    c0 = cyc;
    set_port(1, 4'd7, 32'h1111, 6'd4);
    set_port(3, 4'd7, 32'h3333, 6'd3);
    expect_wr(3, 4'd7, 32'h3333, c0 + 2);
    expect_wr(1, 4'd7, 32'h1111, c0 + 3);
    repeat (5) step();

    // Seq wrap: 63 older than 0
    c0 = cyc;
    set_port(0, 4'd9, 32'h9090, 6'd63);
    set_port(2, 4'd9, 32'h9292, 6'd0);
    expect_wr(0, 4'd9, 32'h9090, c0 + 2);
    expect_wr(2, 4'd9, 32'h9292, c0 + 3);
    repeat (5) step();

    // Equal seq: higher port first
    c0 = cyc;
    set_port(0, 4'd6, 32'h6060, 6'd20);
    set_port(2, 4'd6, 32'h6262, 6'd20);
    expect_wr(2, 4'd6, 32'h6262, c0 + 2);
    expect_wr(0, 4'd6, 32'h6060, c0 + 3);
    repeat (5) step();

    // All ports, distinct addresses: one issue group
    c0 = cyc;
    set_port(0, 4'd1, 32'hC0, 6'd10);
    set_port(1, 4'd2, 32'hC1, 6'd11);
    set_port(2, 4'd3, 32'hC2, 6'd12);
    set_port(3, 4'd4, 32'hC3, 6'd13);
    for (int unsigned p = 0; p < 4; p++)
      expect_wr(p, 4'(p + 1), 32'hC0 + p, c0 + 2);
    repeat (5) step();

    // Port 2 fills while blocked by older port 3 heads at the same address
    c0 = cyc;
    for (int unsigned b = 0; b < D + 1; b++) begin
      set_port(3, 4'd11, 32'h300 + b, 6'(20 + b));
      set_port(2, 4'd11, 32'h200 + b, 6'(30 + b));
      if (b < D) chk($sformatf("fill_ready2_b%0d", b), ready[2], 1'b1);
      else       chk("fill_ready2_full", ready[2], 1'b0);
      expect_wr(3, 4'd11, 32'h300 + b, c0 + 2 + b);
      if (b < D) expect_wr(2, 4'd11, 32'h200 + b, c0 + 7 + b);
      step();
    end
    repeat (10) step();
    chk("fill_idle_after", idle, 1'b1);

    // Reset with three entries buffered
    set_port(0, 4'd1, 32'hE0, 6'd40);
    set_port(1, 4'd2, 32'hE1, 6'd41);
    set_port(2, 4'd3, 32'hE2, 6'd42);
    step();
    chk("buf_idle_busy", idle, 1'b0);
    arst_n = 1'b0;
    #1;
    chk("midrst_en", en, 4'h0);
    chk("midrst_idle", idle, 1'b1);
    chk("midrst_ready", ready, 4'h0);
    repeat (2) step();
    arst_n = 1'b1;
    #1;
    chk("midrst_ready_release", ready, 4'hF);
    repeat (6) step();
    chk("midrst_idle_after", idle, 1'b1);

    // Write to register 0
    c0 = cyc;
    set_port(1, 4'd0, 32'h77, 6'd5);
`ifndef RF_WRITEBACK_ZERO_REG_EN
    expect_wr(1, 4'd0, 32'h77, c0 + 2);
`endif
    step();
    chk("zr_ready", ready[1], 1'b1);
`ifdef RF_WRITEBACK_ZERO_REG_EN
    chk("zr_idle_c1", idle, 1'b1);
    step();
    chk("zr_idle_c2", idle, 1'b1);
    chk("zr_en_c2", en, 4'h0);
`else
    chk("zr_idle_c1", idle, 1'b0);
    step();
    chk("zr_idle_c2", idle, 1'b0);
`endif
    repeat (3) step();
    chk("zr_idle_after", idle, 1'b1);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
